// File: rtl/vdp_cpu_port_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vdp_cpu_port_if                                            |
// | Description : Z80 I/O bus bundle between the CPU and the VDP CPU port.   |
// |               master = CPU side, slave = VDP side.                       |
// |   cpu_en      1  one-clk strobe per CPU clock edge                       |
// |   io_addr     8  CPU address[7:0]                                        |
// |   io_rd_n     1  active-low I/O read                                     |
// |   io_wr_n     1  active-low I/O write                                    |
// |   cpu_dout    8  CPU write data                                          |
// |   cpu_din     8  read data returned by the VDP                           |
// |   cpu_din_sel 1  VDP is driving cpu_din                                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface vdp_cpu_port_if;
  logic       cpu_en;
  logic [7:0] io_addr;
  logic       io_rd_n;
  logic       io_wr_n;
  logic [7:0] cpu_dout;
  logic [7:0] cpu_din;
  logic       cpu_din_sel;

  modport master (
    output cpu_en, io_addr, io_rd_n, io_wr_n, cpu_dout,
    input  cpu_din, cpu_din_sel
  );

  modport slave (
    input  cpu_en, io_addr, io_rd_n, io_wr_n, cpu_dout,
    output cpu_din, cpu_din_sel
  );
endinterface
`default_nettype wire

// File: rtl/vdp_cpu_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vdp_cpu_port                                               |
// | Description : TMS9918-style CPU port front-end. Decodes the data and     |
// |               control I/O ports, holds the address latch, the 8 VDP      |
// |               registers, the status flags and the read-ahead buffer.     |
// | Ports       : clk, reset_n (async, active low)                           |
// |               bus        CPU I/O bus (slave modport)                     |
// |               vram_*     VRAM address, write strobe/data, read strobe/data|
// |               vblank     vertical blank pulse (sets F)                   |
// |               coinc      sprite coincidence pulse (sets C)               |
// |               regs       {r7..r0}                                        |
// |               n_int      active-low interrupt, !(F & r1[5]), registered  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module vdp_cpu_port #(
  parameter logic [7:0] DATA_PORT = 8'h98,
  parameter logic [7:0] CTRL_PORT = 8'h99
) (
  input  logic        clk,
  input  logic        reset_n,
  vdp_cpu_port_if.slave bus,
  output logic [13:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  output logic        vram_re,
  input  logic [7:0]  vram_rdata,
  input  logic        vblank,
  input  logic        coinc,
  output logic [63:0] regs,
  output logic        n_int
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_CAPT  = 2'd2
  } pf_state_e;

  pf_state_e   state_q, state_d;
  logic        toggle_q, toggle_d;
  logic [7:0]  first_byte_q, first_byte_d;
  logic [13:0] vram_addr_q, vram_addr_d;
  logic [7:0]  read_buf_q, read_buf_d;
  logic [63:0] regs_q, regs_d;
  logic        f_q, f_d;
  logic        c_q, c_d;
  logic        vram_we_q, vram_we_d;
  logic [7:0]  vram_wdata_q, vram_wdata_d;
  logic [7:0]  cpu_din_q, cpu_din_d;
  logic        cpu_din_sel_q, cpu_din_sel_d;
  logic        n_int_q, n_int_d;
  // Previous cpu_en sample of {rd_data, rd_ctrl, wr_data, wr_ctrl} matches.
  logic [3:0]  hit_prev_q, hit_prev_d;

  logic [3:0]  hit;
  logic [3:0]  rise;
  logic [3:0]  fall;
  logic        start_pf;

  always_comb begin
    hit[3] = !bus.io_rd_n && (bus.io_addr == DATA_PORT);
    hit[2] = !bus.io_rd_n && (bus.io_addr == CTRL_PORT);
    hit[1] = !bus.io_wr_n && (bus.io_addr == DATA_PORT);
    hit[0] = !bus.io_wr_n && (bus.io_addr == CTRL_PORT);
    rise   = hit & ~hit_prev_q;
    fall   = ~hit & hit_prev_q;
  end

  always_comb begin
    state_d       = state_q;
    toggle_d      = toggle_q;
    first_byte_d  = first_byte_q;
    vram_addr_d   = vram_addr_q;
    read_buf_d    = read_buf_q;
    regs_d        = regs_q;
    f_d           = f_q;
    c_d           = c_q;
    vram_we_d     = 1'b0;
    vram_wdata_d  = vram_wdata_q;
    cpu_din_d     = cpu_din_q;
    cpu_din_sel_d = cpu_din_sel_q;
    hit_prev_d    = hit_prev_q;
    start_pf      = 1'b0;

    // Post-increment one clk after the write strobe, so the strobe sees the
    // un-incremented address.
    if (vram_we_q) begin
      vram_addr_d = vram_addr_q + 14'd1;
    end

    case (state_q)
      ST_RD_ISSUE: state_d = ST_RD_CAPT;
      ST_RD_CAPT: begin
        read_buf_d  = vram_rdata;
        vram_addr_d = vram_addr_q + 14'd1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.cpu_en) begin
      hit_prev_d = hit;

      // Read side effects are deferred to the end of the CPU cycle so the
      // data presented during the cycle stays stable.
      if (fall[3]) begin
        toggle_d = 1'b0;
        start_pf = 1'b1;
      end
      if (fall[2]) begin
        toggle_d = 1'b0;
        f_d      = 1'b0;
        c_d      = 1'b0;
      end
      if (fall[3] || fall[2]) begin
        cpu_din_sel_d = 1'b0;
        cpu_din_d     = 8'h00;
      end

      if (rise[3]) begin
        cpu_din_sel_d = 1'b1;
        cpu_din_d     = read_buf_q;
      end
      if (rise[2]) begin
        cpu_din_sel_d = 1'b1;
        cpu_din_d     = {f_q, 1'b0, c_q, 5'b00000};
      end

      if (rise[0]) begin
        if (!toggle_q) begin
          first_byte_d = bus.cpu_dout;
          toggle_d     = 1'b1;
        end else begin
          toggle_d = 1'b0;
          if (bus.cpu_dout[7]) begin
            regs_d[{bus.cpu_dout[2:0], 3'b000} +: 8] = first_byte_q;
          end else begin
            vram_addr_d = {bus.cpu_dout[5:0], first_byte_q};
            start_pf    = !bus.cpu_dout[6];
          end
        end
      end

      if (rise[1]) begin
        vram_we_d    = 1'b1;
        vram_wdata_d = bus.cpu_dout;
        read_buf_d   = bus.cpu_dout;
        toggle_d     = 1'b0;
      end
    end

    if (start_pf) begin
      state_d = ST_RD_ISSUE;
    end

    // Event pulses override a same-clk clear so no event is lost.
    if (vblank) f_d = 1'b1;
    if (coinc)  c_d = 1'b1;

    n_int_d = !(f_q && regs_q[13]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      toggle_q      <= 1'b0;
      first_byte_q  <= 8'h00;
      vram_addr_q   <= 14'h0000;
      read_buf_q    <= 8'h00;
      regs_q        <= 64'h0;
      f_q           <= 1'b0;
      c_q           <= 1'b0;
      vram_we_q     <= 1'b0;
      vram_wdata_q  <= 8'h00;
      cpu_din_q     <= 8'h00;
      cpu_din_sel_q <= 1'b0;
      n_int_q       <= 1'b1;
      hit_prev_q    <= 4'h0;
    end else begin
      state_q       <= state_d;
      toggle_q      <= toggle_d;
      first_byte_q  <= first_byte_d;
      vram_addr_q   <= vram_addr_d;
      read_buf_q    <= read_buf_d;
      regs_q        <= regs_d;
      f_q           <= f_d;
      c_q           <= c_d;
      vram_we_q     <= vram_we_d;
      vram_wdata_q  <= vram_wdata_d;
      cpu_din_q     <= cpu_din_d;
      cpu_din_sel_q <= cpu_din_sel_d;
      n_int_q       <= n_int_d;
      hit_prev_q    <= hit_prev_d;
    end
  end

  assign vram_addr       = vram_addr_q;
  assign vram_we         = vram_we_q;
  assign vram_wdata      = vram_wdata_q;
  assign vram_re         = (state_q == ST_RD_ISSUE);
  assign regs            = regs_q;
  assign n_int           = n_int_q;
  assign bus.cpu_din     = cpu_din_q;
  assign bus.cpu_din_sel = cpu_din_sel_q;

endmodule
`default_nettype wire
